fade_banner_display: RTL and testbench



---
 rtl/fade_banner_display_pkg.sv | 55 +++++
 rtl/fade_banner_display_if.sv | 21 ++
 rtl/fade_banner_display_font5x7_rom.sv | 66 ++++++
 rtl/fade_banner_display.sv | 234 +++++++++++++++++++++++
 tb/tb_fade_banner_display.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fade_banner_display_pkg.sv
// Shared types, RGB565 field layout, glyph geometry and helpers for the fade banner renderer.
package fade_banner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT
    } state_t;

    localparam int R_W  = 5;
    localparam int G_W  = 6;
    localparam int B_W  = 5;
    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [3:0] LEVEL_MAX = 4'd8;

    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;
    localparam int CELL_W  = 6;
    localparam int CELL_H  = 8;

    typedef struct packed {
        logic       hit;
        logic [5:0] code;
        logic [2:0] row;
        logic [2:0] col;
    } glyph_addr_t;

    // 0 = blank, 1..26 = A..Z, 27..36 = 0..9
    function automatic logic [5:0] char_code(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A)
            return 6'(c - 8'd64);
        else if (c >= 8'h30 && c <= 8'h39)
            return 6'(c - 8'd21);
        else
            return 6'd0;
    endfunction

    function automatic logic [15:0] scale565(input logic [15:0] c, input logic [3:0] lvl);
        logic [8:0] r;
        logic [9:0] g;
        logic [8:0] b;
        r = 9'(c[R_HI:R_LO]) * 9'(lvl);
        g = 10'(c[G_HI:G_LO]) * 10'(lvl);
        b = 9'(c[B_HI:B_LO]) * 9'(lvl);
        return {R_W'(r >> 3), G_W'(g >> 3), B_W'(b >> 3)};
    endfunction

endpackage

// File: rtl/fade_banner_display_if.sv
// Pixel/control bus between the OLED scan driver (master) and the banner renderer (slave).
interface fade_banner_display_if #(
    parameter int PIX_W = 13
);
    logic             start;
    logic             abort;
    logic [PIX_W-1:0] pixel_index;
    logic [15:0]      oled_data;
    logic             active;
    logic             done;

    modport master (
        output start, abort, pixel_index,
        input  oled_data, active, done
    );

    modport slave (
        input  start, abort, pixel_index,
        output oled_data, active, done
    );
endinterface

// File: rtl/fade_banner_display_font5x7_rom.sv
// 5x7 font ROM for blank, A-Z and 0-9; registered read, bit 4 is the leftmost column.
module font5x7_rom
    import fade_banner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] code,
    input  logic [2:0] row,
    output logic [4:0] bits
);

    logic [34:0] glyph;

    always_comb begin
        glyph = '0;
        case (code)
            6'd1:  glyph = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            6'd2:  glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
            6'd3:  glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
            6'd4:  glyph = {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E};
            6'd5:  glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
            6'd6:  glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
            6'd7:  glyph = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
            6'd8:  glyph = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            6'd9:  glyph = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            6'd10: glyph = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
            6'd11: glyph = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
            6'd12: glyph = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
            6'd13: glyph = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
            6'd14: glyph = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
            6'd15: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            6'd16: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
            6'd17: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
            6'd18: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
            6'd19: glyph = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
            6'd20: glyph = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
            6'd21: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            6'd22: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            6'd23: glyph = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
            6'd24: glyph = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
            6'd25: glyph = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04, 5'h04};
            6'd26: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
            6'd27: glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            6'd28: glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            6'd29: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            6'd30: glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            6'd31: glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            6'd32: glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            6'd33: glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            6'd34: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            6'd35: glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            6'd36: glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: glyph = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bits <= '0;
        else if (int'(row) < GLYPH_H)
            bits <= glyph[34 - 5*int'(row) -: 5];
        else
            bits <= '0;
    end

endmodule

// File: rtl/fade_banner_display.sv
// Full-screen fading text banner for the 96x64 OLED path (2-cycle pixel pipeline).
// Optional HOLD-state blinking is enabled by defining FADE_BANNER_BLINK_EN.
module fade_banner_display
    import fade_banner_pkg::*;
#(
    parameter int          SCREEN_WIDTH    = 96,
    parameter int          SCREEN_HEIGHT   = 64,
    parameter logic [63:0] MSG             = "YOU DIED",
    parameter int          SCALE           = 1,
    parameter int          TEXT_Y          = 28,
    parameter logic [15:0] FG_COLOR        = 16'hFFFF,
    parameter logic [15:0] SHADOW_COLOR    = 16'h7BEF,
    parameter int          FRAMES_PER_STEP = 4,
    parameter int          HOLD_FRAMES     = 120
`ifdef FADE_BANNER_BLINK_EN
    ,
    parameter int          BLINK_FRAMES    = 30
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fade_banner_display_if.slave bus
);

    localparam int NPIX   = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int PIX_W  = $clog2(NPIX);
    localparam int CW     = CELL_W * SCALE;
    localparam int CH     = CELL_H * SCALE;
    localparam int TEXT_W = 8 * CW;
    localparam int TEXT_X = (SCREEN_WIDTH - TEXT_W) / 2;
    localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    state_t            state;
    logic [3:0]        level;
    logic [STEP_W-1:0] step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PIX_W-1:0]  prev_idx;
    logic              fb;
    logic              vis;

`ifdef FADE_BANNER_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
    logic [BLINK_W-1:0] blink_cnt;
`else
    assign vis = 1'b1;
`endif

    // Character cell lookup; negative coordinates (shadow of column/row 0) never hit.
    function automatic glyph_addr_t locate(input int px, input int py);
        glyph_addr_t a;
        int rx, ry, ci;
        a  = '0;
        rx = px - TEXT_X;
        ry = py - TEXT_Y;
        if (px >= 0 && py >= 0 && rx >= 0 && rx < TEXT_W && ry >= 0 && ry < CH) begin
            ci     = rx / CW;
            a.col  = 3'((rx % CW) / SCALE);
            a.row  = 3'(ry / SCALE);
            a.code = char_code(MSG[63 - 8*ci -: 8]);
            a.hit  = (int'(a.col) < GLYPH_W) && (int'(a.row) < GLYPH_H);
        end
        return a;
    endfunction

    function automatic logic pick(input logic [4:0] bits, input logic [2:0] col);
        if (int'(col) < GLYPH_W)
            return bits[3'd4 - col];
        else
            return 1'b0;
    endfunction

    int          x0, y0;
    glyph_addr_t cur, nbr;

    always_comb begin
        x0  = int'(bus.pixel_index) % SCREEN_WIDTH;
        y0  = int'(bus.pixel_index) / SCREEN_WIDTH;
        cur = locate(x0, y0);
        nbr = locate(x0 - 1, y0 - 1);
    end

    assign fb = (bus.pixel_index == '0) && (prev_idx != '0);

    logic [4:0] cur_bits, nbr_bits;

    font5x7_rom u_rom_cur (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (cur.code),
        .row   (cur.row),
        .bits  (cur_bits)
    );

    font5x7_rom u_rom_nbr (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (nbr.code),
        .row   (nbr.row),
        .bits  (nbr_bits)
    );

    logic       s1_valid, s1_hit, s1_nhit;
    logic [2:0] s1_col, s1_ncol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_idx <= '0;
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_nhit  <= 1'b0;
            s1_col   <= '0;
            s1_ncol  <= '0;
        end else begin
            prev_idx <= bus.pixel_index;
            s1_valid <= int'(bus.pixel_index) < NPIX;
            s1_hit   <= cur.hit;
            s1_nhit  <= nbr.hit;
            s1_col   <= cur.col;
            s1_ncol  <= nbr.col;
        end
    end

    logic txt_on, sh_on;
    assign txt_on = s1_valid && s1_hit && pick(cur_bits, s1_col);
    assign sh_on  = s1_valid && s1_nhit && pick(nbr_bits, s1_ncol);

    // Level/visibility change on the fb edge, so pixels sampled before index 0 still see the old frame's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.oled_data <= '0;
        else if (bus.abort || !vis)
            bus.oled_data <= '0;
        else if (txt_on)
            bus.oled_data <= scale565(FG_COLOR, level);
        else if (sh_on)
            bus.oled_data <= scale565(SHADOW_COLOR, level);
        else
            bus.oled_data <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            level      <= '0;
            step_cnt   <= '0;
            hold_cnt   <= '0;
            bus.active <= 1'b0;
            bus.done   <= 1'b0;
`ifdef FADE_BANNER_BLINK_EN
            blink_cnt  <= '0;
            vis        <= 1'b1;
`endif
        end else begin
            bus.done <= 1'b0;
            if (bus.abort) begin
                state      <= IDLE;
                level      <= '0;
                step_cnt   <= '0;
                hold_cnt   <= '0;
                bus.active <= 1'b0;
`ifdef FADE_BANNER_BLINK_EN
                blink_cnt  <= '0;
                vis        <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state      <= FADE_IN;
                            level      <= '0;
                            step_cnt   <= '0;
                            bus.active <= 1'b1;
                        end
                    end
                    FADE_IN: begin
                        if (fb) begin
                            if (level == LEVEL_MAX) begin
                                state    <= HOLD;
                                hold_cnt <= '0;
`ifdef FADE_BANNER_BLINK_EN
                                blink_cnt <= '0;
                                vis       <= 1'b1;
`endif
                            end else if (step_cnt == STEP_W'(FRAMES_PER_STEP - 1)) begin
                                level    <= level + 4'd1;
                                step_cnt <= '0;
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (fb) begin
                            if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                                state    <= FADE_OUT;
                                step_cnt <= '0;
`ifdef FADE_BANNER_BLINK_EN
                                vis      <= 1'b1;
`endif
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
`ifdef FADE_BANNER_BLINK_EN
                                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                                    blink_cnt <= '0;
                                    vis       <= ~vis;
                                end else begin
                                    blink_cnt <= blink_cnt + 1'b1;
                                end
`endif
                            end
                        end
                    end
                    FADE_OUT: begin
                        if (fb) begin
                            if (level == '0) begin
                                state      <= IDLE;
                                bus.active <= 1'b0;
                                bus.done   <= 1'b1;
                            end else if (step_cnt == STEP_W'(FRAMES_PER_STEP - 1)) begin
                                level    <= level - 4'd1;
                                step_cnt <= '0;
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fade_banner_display.sv
// Directed bench for fade_banner_display at default geometry, using short synthetic frames.
module tb_fade_banner_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fade_banner_display_if #(.PIX_W(13)) bus ();

    fade_banner_display #(
        .SCREEN_WIDTH    (96),
        .SCREEN_HEIGHT   (64),
        .MSG             ("YOU DIED"),
        .SCALE           (1),
        .TEXT_Y          (28),
        .FG_COLOR        (16'hFFFF),
        .SHADOW_COLOR    (16'h7BEF),
        .FRAMES_PER_STEP (4),
        .HOLD_FRAMES     (120)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int TXT_IDX = 2712;  // (24,28): top-left pixel of 'Y'
    localparam int SH_IDX  = 2809;  // (25,29): shadow of that pixel

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    logic [63:0] msg = "YOU DIED";
    logic [15:0] f_txt, f_sh;
    logic        f_done, f_act;

    always @(posedge clk) if (bus.done) done_seen++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int idx);
        @(posedge clk);
        #1;
        bus.pixel_index = 13'(idx);
    endtask

    task automatic frame();
        put(0);
        put(TXT_IDX);
        f_done = bus.done;
        f_act  = bus.active;
        put(SH_IDX);
        put(7);
        f_txt = bus.oled_data;
        put(9);
        f_sh = bus.oled_data;
    endtask

    function automatic logic [4:0] font_row(input logic [7:0] c, input int r);
        logic [4:0] rows [7];
        case (c)
            "Y": rows = '{5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
            "O": rows = '{5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
            "U": rows = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
            "D": rows = '{5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11110};
            "I": rows = '{5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            "E": rows = '{5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
            default: rows = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
        endcase
        return rows[r];
    endfunction

    // Message occupies x 24..71, y 28..35 (8 cells of 6x8).
    function automatic bit text_px(input int x, input int y);
        int rx, ry, ci, cx;
        logic [7:0] c;
        logic [4:0] row_bits;
        if (x < 0 || y < 0) return 1'b0;
        rx = x - 24;
        ry = y - 28;
        if (rx < 0 || rx >= 48 || ry < 0 || ry >= 8) return 1'b0;
        ci = rx / 6;
        cx = rx % 6;
        if (cx >= 5 || ry >= 7) return 1'b0;
        c = msg[8*(7-ci) +: 8];
        row_bits = font_row(c, ry);
        return row_bits[4-cx];
    endfunction

    function automatic logic [15:0] tb_scale(input int c, input int l);
        int r, g, b;
        r = ((c >> 11) & 31) * l / 8;
        g = ((c >> 5) & 63) * l / 8;
        b = (c & 31) * l / 8;
        return 16'((r << 11) | (g << 5) | b);
    endfunction

    function automatic logic [15:0] model(input int idx, input int lvl);
        int x, y;
        if (idx >= 6144) return 16'h0;
        x = idx % 96;
        y = idx / 96;
        if (text_px(x, y)) return tb_scale(16'hFFFF, lvl);
        if (text_px(x - 1, y - 1)) return tb_scale(16'h7BEF, lvl);
        return 16'h0;
    endfunction

    task automatic sweep_frame();
        int q[$];
        int exp_idx;
        for (int i = 0; i < 6148; i++) begin
            int idx;
            if (i < 6144)       idx = i;
            else if (i == 6144) idx = 6144;
            else if (i == 6145) idx = 8191;
            else                idx = 9;
            put(idx);
            if (i == 1) begin
                f_done = bus.done;
                f_act  = bus.active;
            end
            q.push_back(idx);
            if (q.size() > 2) begin
                exp_idx = q.pop_front();
                check_eq($sformatf("sweep@%0d", exp_idx), 32'(bus.oled_data), 32'(model(exp_idx, 8)));
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int first_done;
        logic act_185, act_186;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.pixel_index = 13'd1;
        first_done      = 0;
        act_185         = 1'b0;
        act_186         = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_oled", 32'(bus.oled_data), 32'h0);
        check_eq("rst_active", 32'(bus.active), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 2; k++) begin
            frame();
            check_eq("idle_txt", 32'(f_txt), 32'h0);
            check_eq("idle_active", 32'(f_act), 32'h0);
        end

        pulse_start();
        check_eq("start_active", 32'(bus.active), 32'h1);

        // fb count to done: 32 fade-in + 1 hold entry + 120 hold + 32 fade-out + final = 186
        for (int k = 1; k <= 186; k++) begin
            if (k == 40) sweep_frame();
            else         frame();
            if (f_done && first_done == 0) first_done = k;
            if (k == 185) act_185 = f_act;
            if (k == 186) act_186 = f_act;
            if (k == 5) pulse_start();
            if (k == 16) begin
                check_eq("fin_l4_txt", 32'(f_txt), 32'h7BEF);
                check_eq("fin_l4_sh", 32'(f_sh), 32'h39E7);
            end
            if (k == 32) begin
                check_eq("fin_l8_txt", 32'(f_txt), 32'hFFFF);
                check_eq("fin_l8_sh", 32'(f_sh), 32'h7BEF);
            end
            if (k == 169) check_eq("fout_l4_txt", 32'(f_txt), 32'h7BEF);
`ifdef FADE_BANNER_BLINK_EN
            if (k == 62) check_eq("blink_h29", 32'(f_txt), 32'hFFFF);
            if (k == 63) check_eq("blink_h30", 32'(f_txt), 32'h0);
            if (k == 92) check_eq("blink_h59", 32'(f_txt), 32'h0);
            if (k == 93) check_eq("blink_h60", 32'(f_txt), 32'hFFFF);
`endif
        end
        check_eq("done_frame", 32'(first_done), 32'd186);
        check_eq("active_185", 32'(act_185), 32'h1);
        check_eq("active_186", 32'(act_186), 32'h0);
        repeat (3) frame();
        check_eq("done_once", 32'(done_seen), 32'd1);

        pulse_start();
        repeat (40) frame();
        check_eq("hold_txt", 32'(f_txt), 32'hFFFF);
        @(posedge clk);
        #1;
        bus.pixel_index = 13'd0;
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pixel_index = 13'd9;
        check_eq("abort_active", 32'(bus.active), 32'h0);
        check_eq("abort_black", 32'(bus.oled_data), 32'h0);
        repeat (5) frame();
        check_eq("abort_txt", 32'(f_txt), 32'h0);
        check_eq("abort_nodone", 32'(done_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
